bp_resolve_queue: RTL and testbench

//  Consumer end of the branch predictor's IF-side prediction stream. Holds an in-order

---
 rtl/bp_resolve_queue.sv | 118 +++++++++++
 tb/tb_bp_resolve_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_queue.sv
// In-order queue of IF-side branch predictions, checked against actual next PC at WB.
// A mispredict raises a one-cycle flush with the redirect target and empties the queue.
//
// state | meaning
// RUN   | normal operation: accept enqueues, resolve the oldest entry
// FLUSH | one-cycle squash; enq/res inputs ignored, queue already empty
module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_pc,
  input  logic [31:0]              enq_pred_pc,
  output logic                     enq_ready,
  input  logic                     res_valid,
  input  logic [31:0]              res_pc,
  input  logic [31:0]              res_next_pc,
  input  logic                     res_is_ctrl,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         pred_ok_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       pred_mem [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, tail_inc;
  logic              in_run, do_enq, res_fire, res_empty, mismatch, pc_err;

  assign in_run    = (state_q == RUN);
  assign enq_ready = in_run && (count < DEPTH_C);
  assign do_enq    = enq_valid && enq_ready;
  assign res_fire  = in_run && res_valid && (count != '0);
  assign res_empty = in_run && res_valid && (count == '0);
  assign mismatch  = res_fire && (pred_mem[head_q] != res_next_pc);
  assign pc_err    = res_fire && (pc_mem[head_q] != res_pc);
  assign tail_inc  = do_enq ? tail_q + PTR_ONE : tail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mismatch) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[tail_q]   <= enq_pc;
      pred_mem[tail_q] <= enq_pred_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else if (mismatch) begin
      // A same-cycle enqueue is younger than the mispredict and is squashed too.
      head_q <= tail_inc;
      tail_q <= tail_inc;
      count  <= '0;
    end else begin
      tail_q <= tail_inc;
      if (res_fire) head_q <= head_q + PTR_ONE;
      if (do_enq && !res_fire)      count <= count + CNT_ONE;
      else if (!do_enq && res_fire) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      err_sticky  <= 1'b0;
    end else begin
      flush <= mismatch;
      if (mismatch) redirect_pc <= res_next_pc;
      if (pc_err || res_empty) err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_ok_cnt <= '0;
      mispred_cnt <= '0;
    end else if (res_fire && res_is_ctrl) begin
      if (mismatch) begin
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + STAT_ONE;
      end else begin
        if (pred_ok_cnt != '1) pred_ok_cnt <= pred_ok_cnt + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: resolve, mispredict flush, full/wrap, errors, reset.
module tb_bp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_pred_pc = '0;
  logic        enq_ready;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic [31:0] res_next_pc = '0;
  logic        res_is_ctrl = 1'b0;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic [31:0] pred_ok_cnt;
  logic [31:0] mispred_cnt;
  logic        err_sticky;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] mq[$];
  logic [31:0] hp;

  bp_resolve_queue #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_pc(enq_pred_pc), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_next_pc(res_next_pc), .res_is_ctrl(res_is_ctrl),
    .flush(flush), .redirect_pc(redirect_pc), .count(count),
    .pred_ok_cnt(pred_ok_cnt), .mispred_cnt(mispred_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    res_valid = 1'b0;
    res_is_ctrl = 1'b0;
  endtask

  task automatic set_enq(input logic [31:0] pc, input logic [31:0] pred);
    enq_valid = 1'b1;
    enq_pc = pc;
    enq_pred_pc = pred;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [31:0] nxt, input logic ctrl);
    res_valid = 1'b1;
    res_pc = pc;
    res_next_pc = nxt;
    res_is_ctrl = ctrl;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #7;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_err", err_sticky, 0);
    chk("rst_ok", pred_ok_cnt, 0);
    chk("rst_mis", mispred_cnt, 0);
    chk("rst_redir", redirect_pc, 0);

    // 1: non-ctrl correct resolve
    set_enq(32'h100, 32'h104); tick(); idle();
    chk("t1_count1", count, 1);
    set_res(32'h100, 32'h104, 1'b0); tick(); idle();
    chk("t1_count0", count, 0);
    chk("t1_flush", flush, 0);
    chk("t1_ok", pred_ok_cnt, 0);
    chk("t1_mis", mispred_cnt, 0);

    // 2: ctrl correct resolve
    set_enq(32'h200, 32'h240); tick(); idle();
    set_res(32'h200, 32'h240, 1'b1); tick(); idle();
    chk("t2_ok", pred_ok_cnt, 1);
    chk("t2_flush", flush, 0);
    chk("t2_err", err_sticky, 0);

    // 3: mispredict with younger entries in flight
    set_enq(32'h300, 32'h304); tick();
    set_enq(32'h304, 32'h308); tick();
    set_enq(32'h308, 32'h30c); tick(); idle();
    chk("t3_count3", count, 3);
    set_res(32'h300, 32'h380, 1'b1); tick();
    // Inputs held through the flush cycle must be ignored without error.
    set_enq(32'h999, 32'h99c);
    chk("t3_flush", flush, 1);
    chk("t3_redir", redirect_pc, 32'h380);
    chk("t3_count0", count, 0);
    chk("t3_mis", mispred_cnt, 1);
    chk("t3_ready", enq_ready, 0);
    tick(); idle();
    chk("t3_flush_end", flush, 0);
    chk("t3_ready_back", enq_ready, 1);
    chk("t3_count_ign", count, 0);
    chk("t3_err_ign", err_sticky, 0);
    chk("t3_ok_hold", pred_ok_cnt, 1);

    // 4: fill, full enq+res stall, pointer wrap with FIFO order
    for (int i = 0; i < 8; i++) begin
      set_enq(32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4));
      mq.push_back(32'h1000 + 32'(i * 4));
      tick();
    end
    idle();
    chk("t4_full_count", count, 8);
    chk("t4_full_ready", enq_ready, 0);
    hp = mq.pop_front();
    set_enq(32'hdead, 32'hbeef);
    set_res(hp, hp + 32'd4, 1'b0); tick(); idle();
    chk("t4_stall_count", count, 7);
    chk("t4_stall_flush", flush, 0);
    for (int i = 0; i < 20; i++) begin
      set_enq(32'h2000 + 32'(i * 4), 32'h2004 + 32'(i * 4));
      mq.push_back(32'h2000 + 32'(i * 4));
      hp = mq.pop_front();
      set_res(hp, hp + 32'd4, 1'b1);
      tick();
      chk("t4_wrap_flush", flush, 0);
    end
    idle();
    chk("t4_wrap_count", count, 7);
    for (int i = 0; i < 7; i++) begin
      hp = mq.pop_front();
      set_res(hp, hp + 32'd4, 1'b1);
      tick();
    end
    idle();
    chk("t4_drain_count", count, 0);
    chk("t4_drain_ok", pred_ok_cnt, 28);
    chk("t4_drain_err", err_sticky, 0);
    chk("t4_drain_mis", mispred_cnt, 1);

    // 5: protocol errors
    set_res(32'h400, 32'h404, 1'b1); tick(); idle();
    chk("t5_empty_err", err_sticky, 1);
    chk("t5_empty_count", count, 0);
    chk("t5_empty_flush", flush, 0);
    set_enq(32'h410, 32'h414);
    set_res(32'h410, 32'h414, 1'b1); tick(); idle();
    chk("t5_same_count", count, 1);
    chk("t5_same_ok", pred_ok_cnt, 28);
    do_reset();
    chk("t5_rst_err", err_sticky, 0);
    set_enq(32'h500, 32'h504); tick(); idle();
    set_res(32'h5ff, 32'h504, 1'b1); tick(); idle();
    chk("t5_pc_err", err_sticky, 1);
    chk("t5_pc_count", count, 0);
    chk("t5_pc_flush", flush, 0);
    chk("t5_pc_ok", pred_ok_cnt, 1);

    // 6: async reset during the flush cycle
    set_enq(32'h600, 32'h604); tick(); idle();
    set_res(32'h600, 32'h700, 1'b1); tick(); idle();
    chk("t6_flush", flush, 1);
    chk("t6_mis", mispred_cnt, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ok", pred_ok_cnt, 0);
    chk("t6_rst_mis", mispred_cnt, 0);
    chk("t6_rst_err", err_sticky, 0);
    #5;
    rst = 1'b1;
    tick();
    chk("t6_ready", enq_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
